// File: rtl/tone_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tone_pkg : shared constants and types for the tone_synth square-wave voice |
// | Rev 1.0  : initial release                                                 |
// +----------------------------------------------------------------------------+
package tone_pkg;

  localparam int          c_cnt_w_default = 20;
  localparam int unsigned c_num_notes     = 8;

  // C4 D4 E4 F4 G4 A4 B4 C5, in Hz
  localparam int unsigned c_note_hz [0:7] = '{262, 294, 330, 349, 392, 440, 494, 523};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/tone_prio_enc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tone_prio_enc : 8-to-3 priority encoder, lowest set bit wins, with valid   |
// | Rev 1.0       : initial release                                            |
// +----------------------------------------------------------------------------+
module tone_prio_enc (
  input  logic [7:0] i_sel,
  output logic [2:0] o_idx,
  output logic       o_valid
);

  // Scan from the top so the lowest set bit is the last (winning) write.
  always_comb begin
    o_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (i_sel[i]) o_idx = 3'(i);
    end
  end

  assign o_valid = |i_sel;

endmodule
`default_nettype wire

// File: rtl/tone_synth.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tone_synth : one-voice square-wave note generator, glitch-free note change |
// |              Optional TONE_SYNTH_DUTY_EN: VOL selects duty 1/2..1/16.      |
// | Rev 1.0    : initial release                                               |
// +----------------------------------------------------------------------------+
module tone_synth
  import tone_pkg::*;
#(
  parameter int unsigned CLK_HZ = 125000000,
  parameter int          CNT_W  = c_cnt_w_default
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] TONE_SEL,
  input  logic [1:0] VOL,
  output logic       PWM,
  output logic       BUSY,
  output logic [2:0] NOTE_IDX
);

  logic [2:0]       w_idx;
  logic             w_valid;
  logic [CNT_W-1:0] w_tc [0:7];
  logic [CNT_W-1:0] w_tc_sel;
  logic [CNT_W:0]   w_period;
  logic [CNT_W:0]   w_hi_sel;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_tc, w_tc_nxt;
  logic [CNT_W:0]   r_hi, w_hi_nxt;
  logic [2:0]       r_note, w_note_nxt;
  logic             r_pwm, w_pwm_nxt;
  logic             r_busy, w_busy_nxt;

  tone_prio_enc u_prio (
    .i_sel   (TONE_SEL),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  // Terminal counts are elaboration-time constants; no runtime divider.
  for (genvar gi = 0; gi < 8; gi++) begin : g_tc
    localparam int unsigned c_tc = CLK_HZ / c_note_hz[gi] - 1;
    assign w_tc[gi] = CNT_W'(c_tc);
  end

  assign w_tc_sel = w_tc[w_idx];
  assign w_period = {1'b0, w_tc_sel} + 1'b1;

`ifdef TONE_SYNTH_DUTY_EN
  assign w_hi_sel = w_period >> ({1'b0, VOL} + 3'd1);
`else
  logic w_vol_unused;
  assign w_vol_unused = ^VOL;
  assign w_hi_sel     = w_period >> 1;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tc_nxt    = r_tc;
    w_hi_nxt    = r_hi;
    w_note_nxt  = r_note;
    w_pwm_nxt   = r_pwm;
    w_busy_nxt  = r_busy;
    case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_state_nxt = PLAY;
          w_cnt_nxt   = '0;
          w_tc_nxt    = w_tc_sel;
          w_hi_nxt    = w_hi_sel;
          w_note_nxt  = w_idx;
          w_pwm_nxt   = 1'b1;
          w_busy_nxt  = 1'b1;
        end
      end
      PLAY: begin
        // TONE_SEL is only looked at on the last count of a period.
        if (r_cnt == r_tc) begin
          w_cnt_nxt = '0;
          if (w_valid) begin
            w_tc_nxt   = w_tc_sel;
            w_hi_nxt   = w_hi_sel;
            w_note_nxt = w_idx;
            w_pwm_nxt  = 1'b1;
          end else begin
            w_state_nxt = IDLE;
            w_note_nxt  = 3'd0;
            w_pwm_nxt   = 1'b0;
            w_busy_nxt  = 1'b0;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
          w_pwm_nxt = (({1'b0, r_cnt} + 1'b1) < r_hi);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_note_nxt  = 3'd0;
        w_pwm_nxt   = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_tc    <= '0;
      r_hi    <= '0;
      r_note  <= 3'd0;
      r_pwm   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tc    <= w_tc_nxt;
      r_hi    <= w_hi_nxt;
      r_note  <= w_note_nxt;
      r_pwm   <= w_pwm_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign PWM      = r_pwm;
  assign BUSY     = r_busy;
  assign NOTE_IDX = r_note;

endmodule
`default_nettype wire

// File: tb/tb_tone_synth.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_tone_synth : scoreboard bench for tone_synth against a note-level model |
// | Rev 1.0       : initial release                                            |
// +----------------------------------------------------------------------------+
module tb_tone_synth;

  localparam int unsigned c_clk_hz = 26200;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] TONE_SEL = 8'h00;
  logic [1:0] VOL = 2'd0;
  logic       PWM;
  logic       BUSY;
  logic [2:0] NOTE_IDX;

  tone_synth #(.CLK_HZ(c_clk_hz)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .TONE_SEL (TONE_SEL),
    .VOL      (VOL),
    .PWM      (PWM),
    .BUSY     (BUSY),
    .NOTE_IDX (NOTE_IDX)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit pwm;
    bit busy;
    int note;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  // Note-level model: a note occupies a whole period of clk_hz/f cycles.
  int hz [0:7] = '{262, 294, 330, 349, 392, 440, 494, 523};
  bit m_play = 0;
  int m_note = 0;
  int m_pos  = 0;
  int m_per  = 0;
  int m_hi   = 0;

  function automatic void m_start(input logic [7:0] sel, input logic [1:0] vol);
    int k = 0;
    for (int i = 7; i >= 0; i--) if (sel[i]) k = i;
    m_note = k;
    m_per  = int'(c_clk_hz) / hz[k];
`ifdef TONE_SYNTH_DUTY_EN
    m_hi   = m_per >> (int'(vol) + 1);
`else
    m_hi   = m_per / 2;
`endif
    m_pos  = 0;
    m_play = 1;
  endfunction

  function automatic void m_reset();
    m_play = 0;
    m_note = 0;
    m_pos  = 0;
  endfunction

  function automatic void m_clock(input logic [7:0] sel, input logic [1:0] vol);
    if (!m_play) begin
      if (sel != 0) m_start(sel, vol);
    end else if (m_pos == m_per - 1) begin
      if (sel != 0) m_start(sel, vol);
      else m_reset();
    end else begin
      m_pos++;
    end
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.pwm  = m_play && (m_pos < m_hi);
    e.busy = m_play;
    e.note = m_play ? m_note : 0;
    q.push_back(e);
  endfunction

  task automatic step(input logic [7:0] sel, input logic [1:0] vol);
    @(negedge CLK);
    TONE_SEL = sel;
    VOL      = vol;
    @(posedge CLK);
    #1;
    m_clock(sel, vol);
    push_exp();
  endtask

  // Async reset pulse entirely inside the low phase, then one clocked step.
  task automatic step_rst(input logic [7:0] sel, input logic [1:0] vol);
    @(negedge CLK);
    TONE_SEL = sel;
    VOL      = vol;
    #1 RST = 1'b1;
    #1;
    n_vec++;
    if (PWM !== 1'b0 || BUSY !== 1'b0 || NOTE_IDX !== 3'd0) begin
      n_err++;
      $display("FAIL async_reset: got pwm/busy/note %b/%b/%0d want 0/0/0", PWM, BUSY, NOTE_IDX);
    end
    #1 RST = 1'b0;
    m_reset();
    @(posedge CLK);
    #1;
    m_clock(sel, vol);
    push_exp();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_vec++;
        if (PWM !== e.pwm || BUSY !== e.busy || NOTE_IDX !== 3'(e.note)) begin
          n_err++;
          $display("FAIL cycle %0d outputs: got pwm/busy/note %b/%b/%0d want %b/%b/%0d",
                   cyc, PWM, BUSY, NOTE_IDX, e.pwm, e.busy, e.note);
        end
      end
    end
  end

  initial begin : stim
    logic [7:0] sel;
    logic [1:0] vol;
    int         r;
    int         len;

    #2;
    n_vec++;
    if (PWM !== 1'b0 || BUSY !== 1'b0 || NOTE_IDX !== 3'd0) begin
      n_err++;
      $display("FAIL reset_state: got pwm/busy/note %b/%b/%0d want 0/0/0", PWM, BUSY, NOTE_IDX);
    end
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    m_reset();

    // C4 held: 100-cycle period, 50 high
    repeat (250) step(8'h01, 2'd0);
    repeat (110) step(8'h00, 2'd0);
    // C4 + A4 requested together: C4 must win
    repeat (220) step(8'h21, 2'd1);
    repeat (110) step(8'h00, 2'd0);
    // note change mid-period, then stop mid-period
    repeat (31) step(8'h01, 2'd0);
    repeat (150) step(8'h20, 2'd2);
    repeat (110) step(8'h00, 2'd0);
    // reset mid-period, then C5
    repeat (41) step(8'h01, 2'd3);
    step_rst(8'h80, 2'd0);
    repeat (120) step(8'h80, 2'd0);

    for (int s = 0; s < 40; s++) begin
      r = $urandom_range(0, 9);
      if (r < 2)      sel = 8'h00;
      else if (r < 7) sel = 8'(1 << $urandom_range(0, 7));
      else            sel = 8'($urandom_range(1, 255));
      vol = 2'($urandom_range(0, 3));
      len = $urandom_range(1, 160);
      if ($urandom_range(0, 7) == 0) step_rst(sel, vol);
      repeat (len) step(sel, vol);
    end
    repeat (120) step(8'h00, 2'd0);

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge CLK);
    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d pending entries want 0", q.size());
    end
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tone_synth.md
TONE_SYNTH -- requirements
Module: tone_synth

Interface
REQ-001 SHALL have parameter CLK_HZ, default 125000000, meaning input clock frequency in Hz.
REQ-002 SHALL have parameter CNT_W, default 20, meaning period counter width in bits.
REQ-003 SHALL have port CLK  input  1  meaning the single clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  meaning reset, asynchronous and active-high.
REQ-005 SHALL have port TONE_SEL  input  8  meaning one-hot note request from the sequencer; bit0=C4 .. bit7=C5; 0 = silence.
REQ-006 SHALL have port VOL  input  2  meaning duty select, used only when DUTY_EN is defined.
REQ-007 SHALL have port PWM  output  1  meaning registered square-wave audio output.
REQ-008 SHALL have port BUSY  output  1  meaning high while in PLAY.
REQ-009 SHALL have port NOTE_IDX  output  3  meaning index of the note currently sounding; 0 when idle.

Function
REQ-010 SHALL use note frequencies 262, 294, 330, 349, 392, 440, 494, 523 Hz for indices 0..7.
REQ-011 SHALL compute period terminal count N = CLK_HZ/f - 1 with truncating integer division, at elaboration time.
REQ-012 SHALL resolve TONE_SEL with lowest-set-bit priority when more than one bit is set.
REQ-013 SHALL implement a two-state FSM: IDLE and PLAY.
REQ-014 In IDLE, on a cycle with TONE_SEL != 0, SHALL next cycle enter PLAY, latch NOTE_IDX and N, set cnt=0, PWM=1, BUSY=1.
REQ-015 In PLAY, SHALL increment cnt each cycle; PWM = 1 while cnt < H, else 0, where H is the high-time count.
REQ-016 At cnt==N with TONE_SEL==0, SHALL next cycle enter IDLE with PWM=0, BUSY=0, NOTE_IDX=0, cnt=0.
REQ-017 At cnt==N with TONE_SEL!=0, SHALL relatch note from current TONE_SEL, reset cnt to 0, drive PWM=1.
REQ-018 SHALL ignore TONE_SEL changes mid-period; every note change or stop takes effect only at a period boundary (glitch-free).
REQ-019 SHALL register PWM, BUSY and NOTE_IDX; no combinational path from TONE_SEL to any output.
REQ-020 Without DUTY_EN, SHALL use H = (N+1)>>1, giving 50% duty.

Reset
REQ-021 On RST high, SHALL asynchronously force IDLE, cnt=0, PWM=0, BUSY=0, NOTE_IDX=0.
REQ-022 Reset asserted mid-period SHALL abort the note; after release, SHALL behave as from IDLE on the next cycle.

Configuration
REQ-023 Macro TONE_SYNTH_DUTY_EN SHALL, when defined, set H = (N+1)>>(VOL+1), giving duty 1/2, 1/4, 1/8, 1/16 for VOL 0..3.
REQ-024 With DUTY_EN defined, SHALL sample VOL only at period start, alongside the note.
REQ-025 Without the macro, SHALL leave VOL unconnected internally and fix duty at 50%.

Structure
REQ-026 Package tone_pkg SHALL hold the note frequency table, the state enum (IDLE, PLAY) and the default CNT_W.
REQ-027 SHALL instantiate one sub-module, tone_prio_enc, an 8-to-3 lowest-bit priority encoder with a valid flag.
REQ-028 SHALL be sized so N for C4 at the default CLK_HZ (477098) fits CNT_W.

Verification (CLK_HZ=26200: N(C4)=99, N(A4)=58, N(C5)=49)
REQ-029 TONE_SEL=0x01 held -> PWM period 100 cycles, high 50 cycles, NOTE_IDX=0, BUSY=1.
REQ-030 TONE_SEL=0x21 -> C4 selected (lowest bit), not A4; period 100.
REQ-031 Switch 0x01->0x20 at cnt=30 -> C4 period completes at 100 cycles; next period 59 cycles, NOTE_IDX=5.
REQ-032 TONE_SEL to 0 mid-period -> period finishes; next cycle PWM=0, BUSY=0, NOTE_IDX=0.
REQ-033 RST pulse at cnt=40 -> outputs 0 immediately without a clock edge; TONE_SEL=0x80 after release -> 50-cycle period.
REQ-034 DUTY_EN, VOL=2, TONE_SEL=0x01 -> high 12 cycles of 100.
